pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer side of the hazard stall request. Turns hazard stall, branch redirect and the
//  data-memory ready handshake into per-stage write enables, IF/ID flush and ID/EX bubble.
//  Sits in the core top between hazard_detector/branch compare and the pipeline registers.
//  Also keeps stall/flush performance counters and a memory-wait timeout.
// PARAMETERS
//  CNT_W         32  width of the saturating perf counters stall_cnt_o / flush_cnt_o
//  MAX_MEM_WAIT  15  consecutive wait cycles before timeout; valid range 1..255
// PORTS
//  clk              in   1      core clock, rising edge
//  rst              in   1      asynchronous, active-high reset
//  hazard_stall_i   in   1      stall request from the hazard detector (ID stage)
//  branch_taken_i   in   1      branch resolved taken in ID; PC redirect this cycle
//  mem_req_i        in   1      MEM stage holds a load/store
//  mem_ready_i      in   1      data memory completes the MEM-stage access this cycle
//  pc_write_o       out  1      PC register enable
//  ifid_write_o     out  1      IF/ID register enable
//  ifid_flush_o     out  1      clear IF/ID to NOP
//  idex_bubble_o    out  1      load NOP controls into ID/EX
//  exmem_write_o    out  1      EX/MEM register enable
//  memwb_write_o    out  1      MEM/WB register enable
//  mem_timeout_o    out  1      sticky memory-wait timeout flag
//  state_o          out  2      FSM state, debug
//  stall_cnt_o      out  CNT_W  cycles with a hazard bubble inserted
//  flush_cnt_o      out  CNT_W  cycles with an IF/ID flush issued
// BEHAVIOUR
//  - Reset (async assert): state=RUN, wait_cnt=0, counters=0, mem_timeout_o=0.
//    While rst=1 all write enables, flush and bubble are 0.
//  - Outputs are combinational from state and inputs. Counters, flag and state update
//    on posedge clk.
//  - freeze = mem_req_i & ~mem_ready_i. Priority: ERR > freeze > hazard > branch > run.
//  - ERR: all enables, flush and bubble 0; state held until reset.
//  - freeze: all enables 0, ifid_flush_o=0, idex_bubble_o=0 (whole pipe holds).
//    Hazard and branch inputs are ignored and re-evaluated once the freeze ends.
//  - hazard (no freeze): pc_write_o=0, ifid_write_o=0, idex_bubble_o=1,
//    exmem_write_o=memwb_write_o=1, ifid_flush_o=0. A branch with a pending hazard
//    does not flush. stall_cnt_o += 1.
//  - branch (no freeze, no hazard): pc_write_o=1, ifid_write_o=1, ifid_flush_o=1,
//    idex_bubble_o=0, rest=1. flush_cnt_o += 1.
//  - run: all enables 1, flush=bubble=0.
//  - FSM states: RUN=2'd0, MEMWAIT=2'd1, ERR=2'd2.
//    RUN -> MEMWAIT when freeze=1, wait_cnt <= 1.
//    MEMWAIT stays while freeze=1, wait_cnt += 1.
//    MEMWAIT -> RUN when mem_ready_i=1 (or mem_req_i drops), wait_cnt <= 0.
//      The enables on that exit cycle follow the hazard/branch/run rules.
//    MEMWAIT -> ERR when freeze=1 and wait_cnt == MAX_MEM_WAIT; mem_timeout_o <= 1.
//  - A request with mem_ready_i=1 in the same cycle (zero-wait) never leaves RUN.
//  - Counters saturate at all-ones and do not wrap. wait_cnt is 8 bits.
//  - Reset mid-MEMWAIT or in ERR returns to RUN with every count cleared.
// STRUCTURE
//  - Shared header PIPE_CTRL.v (same style as INST_OPCODE.v): `define for the state
//    encodings RUN/MEMWAIT/ERR.
//  - One sub-module, sat_counter #(W): enable, saturating increment, async clear.
//    Instantiated for stall_cnt_o and flush_cnt_o. The wait counter is kept inline.
// TESTING
//  1 rst=1 mid-run -> all enables 0 immediately, no clk edge needed.
//    Release rst -> state_o=0, counters 0.
//  2 hazard_stall_i=1 for 2 cycles -> pc_write_o=ifid_write_o=0, idex_bubble_o=1 both
//    cycles; stall_cnt_o=2.
//  3 hazard_stall_i=1 & branch_taken_i=1 -> no flush, bubble=1.
//    Next cycle hazard=0, branch=1 -> ifid_flush_o=1, flush_cnt_o=1.
//  4 mem_req_i=1, mem_ready_i=0 for 3 cycles, then ready=1 -> all enables 0 for 3 cycles.
//    state_o=1 from cycle 2. Ready cycle: enables 1, then state_o=0.
//  5 MAX_MEM_WAIT=4, mem_ready_i held 0 -> state_o=2 and mem_timeout_o=1 after 5 edges.
//    Enables stay 0 until rst.
//  6 force 2^CNT_W-1 hazard cycles (CNT_W=4) -> stall_cnt_o stays 4'hF.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared state encoding for the pipeline stall controller
package pipeline_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ERR     = 2'd2
   } state_t;

   localparam int WAIT_W = 8;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// rtl/pipeline_stall_ctrl_sat_counter.sv - enabled saturating up-counter with async clear
module pipeline_stall_ctrl_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   // Holds at all-ones rather than wrapping back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stage enables, flush/bubble, perf counters and memory-wait timeout
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int MAX_MEM_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_stall_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             exmem_write_o,
   output logic             memwb_write_o,
   output logic             mem_timeout_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(MAX_MEM_WAIT);

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_nxt;
   logic              go_err;
   logic              freeze;
   logic              stall_inc;
   logic              flush_inc;

   assign freeze  = mem_req_i & ~mem_ready_i;
   assign state_o = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RUN;
         wait_cnt      <= '0;
         mem_timeout_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (go_err) begin
            mem_timeout_o <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      go_err    = 1'b0;
      case (state)
         RUN: begin
            if (freeze) begin
               state_nxt = MEMWAIT;
               wait_nxt  = WAIT_W'(1);
            end
         end
         MEMWAIT: begin
            if (!freeze) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else if (wait_cnt == MAX_WAIT) begin
               state_nxt = ERR;
               go_err    = 1'b1;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         ERR: begin
            state_nxt = ERR;
         end
         default: begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   // Stage control: the exit cycle of MEMWAIT is decided by freeze alone, not by state.
   always_comb begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      exmem_write_o = 1'b0;
      memwb_write_o = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      if (!rst && (state != ERR) && !freeze) begin
         exmem_write_o = 1'b1;
         memwb_write_o = 1'b1;
         if (hazard_stall_i) begin
            idex_bubble_o = 1'b1;
            stall_inc     = 1'b1;
         end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = branch_taken_i;
            flush_inc    = branch_taken_i;
         end
      end
   end

   pipeline_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall_inc),
      .count (stall_cnt_o)
   );

   pipeline_stall_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (flush_inc),
      .count (flush_cnt_o)
   );

endmodule
